// File: rtl/prt_phy_rcfg_arb.sv
// rtl/prt_phy_rcfg_arb.sv - round-robin arbiter sharing one PHY reconfig port among P_REQS requesters
// One transaction in flight; registered master strobes; watchdog aborts a hung waitrequest.
module prt_phy_rcfg_arb #(
    parameter int P_REQS      = 2,
    parameter int P_RCFG_ADR  = 10,
    parameter int P_RCFG_DAT  = 32,
    parameter int P_TO_CYCLES = 1024
) (
    input  logic                           RST_IN,
    input  logic                           CLK_IN,
    input  logic [P_REQS*P_RCFG_ADR-1:0]   REQ_ADR_IN,
    input  logic [P_REQS-1:0]              REQ_WR_IN,
    input  logic [P_REQS-1:0]              REQ_RD_IN,
    input  logic [P_REQS*P_RCFG_DAT-1:0]   REQ_DAT_IN,
    output logic [P_RCFG_DAT-1:0]          REQ_DAT_OUT,
    output logic [P_REQS-1:0]              REQ_WAIT_OUT,
    output logic [P_RCFG_ADR-1:0]          RCFG_ADR_OUT,
    output logic                           RCFG_WR_OUT,
    output logic                           RCFG_RD_OUT,
    output logic [P_RCFG_DAT-1:0]          RCFG_DAT_OUT,
    input  logic [P_RCFG_DAT-1:0]          RCFG_DAT_IN,
    input  logic                           RCFG_WAIT_IN,
    output logic                           ERR_OUT
);

    localparam int              IW       = $clog2(P_REQS);
    localparam int              WW       = $clog2(P_TO_CYCLES);
    localparam logic [WW-1:0]   WD_MAX   = WW'(P_TO_CYCLES - 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(P_REQS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           gnt_q, gnt_d;
    logic [P_RCFG_ADR-1:0]   adr_q, adr_d;
    logic [P_RCFG_DAT-1:0]   wdat_q, wdat_d;
    logic                    wr_q, wr_d;
    logic                    rd_q, rd_d;
    logic [WW-1:0]           wd_q, wd_d;
    logic [P_RCFG_DAT-1:0]   rdat_q, rdat_d;
    logic [P_REQS-1:0]       wait_q, wait_d;
    logic                    err_q, err_d;

    logic [P_REQS-1:0]       req_vec;
    logic                    sel_vld;
    logic [IW-1:0]           sel_idx;
    logic [IW-1:0]           cand;

    // Scan from the highest offset down so the last hit is the first requester at/after ptr.
    always_comb begin
        req_vec = REQ_WR_IN | REQ_RD_IN;
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = P_REQS - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % P_REQS);
            if (req_vec[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        wd_d    = wd_q;
        rdat_d  = rdat_q;
        wait_d  = '1;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    gnt_d   = sel_idx;
                    adr_d   = REQ_ADR_IN[sel_idx*P_RCFG_ADR +: P_RCFG_ADR];
                    wdat_d  = REQ_DAT_IN[sel_idx*P_RCFG_DAT +: P_RCFG_DAT];
                    // A simultaneous wr+rd is served as a write only.
                    wr_d    = REQ_WR_IN[sel_idx];
                    rd_d    = ~REQ_WR_IN[sel_idx];
                    wd_d    = '0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!RCFG_WAIT_IN) begin
                    if (rd_q) begin
                        rdat_d = RCFG_DAT_IN;
                    end
                    wr_d           = 1'b0;
                    rd_d           = 1'b0;
                    wait_d[gnt_q]  = 1'b0;
                    state_d        = ST_DONE;
                end else if (wd_q == WD_MAX) begin
                    wr_d           = 1'b0;
                    rd_d           = 1'b0;
                    rdat_d         = '1;
                    err_d          = 1'b1;
                    wait_d[gnt_q]  = 1'b0;
                    state_d        = ST_DONE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end

            ST_DONE: begin
                ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + IW'(1);
                wd_d    = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wd_q    <= '0;
            rdat_q  <= '0;
            wait_q  <= '1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            rdat_q  <= rdat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign REQ_DAT_OUT  = rdat_q;
    assign REQ_WAIT_OUT = wait_q;
    assign RCFG_ADR_OUT = adr_q;
    assign RCFG_WR_OUT  = wr_q;
    assign RCFG_RD_OUT  = rd_q;
    assign RCFG_DAT_OUT = wdat_q;
    assign ERR_OUT      = err_q;

endmodule

// File: tb/tb_prt_phy_rcfg_arb.sv
// tb/tb_prt_phy_rcfg_arb.sv - directed and randomized checks of prt_phy_rcfg_arb against a transaction model
module tb_prt_phy_rcfg_arb;

    localparam int P_REQS = 3;
    localparam int A      = 10;
    localparam int D      = 32;
    localparam int TO     = 8;

    logic                  clk;
    logic                  rst;
    logic [P_REQS*A-1:0]   req_adr;
    logic [P_REQS-1:0]     req_wr;
    logic [P_REQS-1:0]     req_rd;
    logic [P_REQS*D-1:0]   req_dat;
    logic [D-1:0]          rcfg_dat;
    logic                  rcfg_wait;

    logic [D-1:0]          REQ_DAT_OUT;
    logic [P_REQS-1:0]     REQ_WAIT_OUT;
    logic [A-1:0]          RCFG_ADR_OUT;
    logic                  RCFG_WR_OUT;
    logic                  RCFG_RD_OUT;
    logic [D-1:0]          RCFG_DAT_OUT;
    logic                  ERR_OUT;

    prt_phy_rcfg_arb #(
        .P_REQS      (P_REQS),
        .P_RCFG_ADR  (A),
        .P_RCFG_DAT  (D),
        .P_TO_CYCLES (TO)
    ) dut (
        .RST_IN       (rst),
        .CLK_IN       (clk),
        .REQ_ADR_IN   (req_adr),
        .REQ_WR_IN    (req_wr),
        .REQ_RD_IN    (req_rd),
        .REQ_DAT_IN   (req_dat),
        .REQ_DAT_OUT  (REQ_DAT_OUT),
        .REQ_WAIT_OUT (REQ_WAIT_OUT),
        .RCFG_ADR_OUT (RCFG_ADR_OUT),
        .RCFG_WR_OUT  (RCFG_WR_OUT),
        .RCFG_RD_OUT  (RCFG_RD_OUT),
        .RCFG_DAT_OUT (RCFG_DAT_OUT),
        .RCFG_DAT_IN  (rcfg_dat),
        .RCFG_WAIT_IN (rcfg_wait),
        .ERR_OUT      (ERR_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Transaction-level reference: phase 0 = free, 1 = master strobing, 2 = completion cycle.
    int          m_ph, m_gnt, m_ptr, m_cnt;
    bit          m_is_wr, m_err;
    logic [A-1:0] m_adr;
    logic [D-1:0] m_dat, m_rdat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [P_REQS-1:0] reqs, input int ptr);
        for (int k = 0; k < P_REQS; k++) begin
            if (reqs[(ptr + k) % P_REQS]) return (ptr + k) % P_REQS;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_gnt = 0; m_ptr = 0; m_cnt = 0;
        m_is_wr = 1'b0; m_err = 1'b0;
        m_adr = '0; m_dat = '0; m_rdat = '0;
    endtask

    task automatic model_step();
        int g;
        m_err = 1'b0;
        case (m_ph)
            0: begin
                g = pick(req_wr | req_rd, m_ptr);
                if (g >= 0) begin
                    m_gnt   = g;
                    m_is_wr = req_wr[g];
                    m_adr   = req_adr[g*A +: A];
                    m_dat   = req_dat[g*D +: D];
                    m_cnt   = 0;
                    m_ph    = 1;
                end
            end
            1: begin
                if (!rcfg_wait) begin
                    if (!m_is_wr) m_rdat = rcfg_dat;
                    m_ph = 2;
                end else if (m_cnt == TO - 1) begin
                    m_rdat = '1;
                    m_err  = 1'b1;
                    m_ph   = 2;
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                m_ptr = (m_gnt + 1) % P_REQS;
                m_ph  = 0;
            end
        endcase
    endtask

    task automatic check_all();
        logic [P_REQS-1:0] exp_wait;
        exp_wait = '1;
        if (m_ph == 2) exp_wait[m_gnt] = 1'b0;
        chk("rcfg_wr", RCFG_WR_OUT, m_ph == 1 && m_is_wr);
        chk("rcfg_rd", RCFG_RD_OUT, m_ph == 1 && !m_is_wr);
        chk("req_wait", REQ_WAIT_OUT, exp_wait);
        chk("err", ERR_OUT, m_err);
        chk("req_dat", REQ_DAT_OUT, m_rdat);
        if (m_ph == 1) begin
            chk("rcfg_adr", RCFG_ADR_OUT, m_adr);
            if (m_is_wr) chk("rcfg_dat", RCFG_DAT_OUT, m_dat);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_adr", RCFG_ADR_OUT, '0);
        chk("rst_dat", RCFG_DAT_OUT, '0);
        #1;
        rst = 1'b0;
    endtask

    int nwr, nrd, nlow, nlow0, nlow1, nerr, novl, kind, first_seen;
    int gq[$];
    int cq[$];
    logic [A-1:0] first_adr;
    logic [P_REQS-1:0] pend, wr_v, rd_v;

    initial begin
        rst = 1'b1; req_adr = '0; req_wr = '0; req_rd = '0; req_dat = '0;
        rcfg_dat = '0; rcfg_wait = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_adr", RCFG_ADR_OUT, '0);
        chk("rst_dat", RCFG_DAT_OUT, '0);
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // single write, requester 1, wait held for three strobe cycles
        req_adr[1*A +: A] = 10'h123; req_dat[1*D +: D] = 32'hA5A5_0001;
        req_wr = 3'b010; rcfg_wait = 1'b1;
        nwr = 0; nlow = 0; nlow0 = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rcfg_wait = 1'b0;
            cyc();
            if (RCFG_WR_OUT) begin
                nwr++;
                chk("wr_adr", RCFG_ADR_OUT, 10'h123);
                chk("wr_dat", RCFG_DAT_OUT, 32'hA5A5_0001);
            end
            if (!REQ_WAIT_OUT[0]) nlow0++;
            if (!REQ_WAIT_OUT[1]) begin nlow++; req_wr = '0; end
        end
        chk("wr_strobe_cycles", nwr, 4);
        chk("wr_completions", nlow, 1);
        chk("wr_other_wait", nlow0, 0);

        // read, requester 0
        req_adr[0 +: A] = 10'h040; req_rd = 3'b001; rcfg_dat = 32'hCAFE_F00D;
        nlow = 0; novl = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (RCFG_WR_OUT && RCFG_RD_OUT) novl++;
            if (!REQ_WAIT_OUT[0]) begin
                nlow++;
                chk("rd_data", REQ_DAT_OUT, 32'hCAFE_F00D);
                req_rd = '0;
            end
        end
        chk("rd_completions", nlow, 1);
        chk("rd_overlap", novl, 0);

        // round robin from a freshly reset pointer
        pulse_reset();
        for (int i = 0; i < P_REQS; i++) begin
            req_adr[i*A +: A] = A'(10'h100 + i);
            req_dat[i*D +: D] = D'(i);
        end
        req_wr = 3'b111;
        for (int c = 0; c < 18; c++) begin
            cyc();
            for (int i = 0; i < P_REQS; i++) begin
                if (!REQ_WAIT_OUT[i]) begin gq.push_back(i); cq.push_back(c); end
            end
        end
        chk("rr_count", gq.size(), 6);
        for (int k = 0; k < 6 && k < gq.size(); k++) begin
            chk("rr_order", gq[k], k % P_REQS);
            chk("rr_spacing", cq[k], 1 + 3 * k);
        end

        // watchdog: requester 0 reads into a stuck waitrequest, requester 1 waits behind it
        req_wr = 3'b010; req_rd = 3'b001;
        req_adr[1*A +: A] = 10'h2AA;
        rcfg_wait = 1'b1;
        nrd = 0; nerr = 0; nlow1 = 0; first_seen = 0; first_adr = '0;
        for (int c = 0; c < 14; c++) begin
            if (c == 9) rcfg_wait = 1'b0;
            cyc();
            if (RCFG_RD_OUT) nrd++;
            if (ERR_OUT) nerr++;
            if (RCFG_WR_OUT && nerr > 0 && first_seen == 0) begin
                first_seen = 1;
                first_adr  = RCFG_ADR_OUT;
            end
            if (!REQ_WAIT_OUT[0]) begin
                chk("to_data", REQ_DAT_OUT, 32'hFFFF_FFFF);
                chk("to_err", ERR_OUT, 1'b1);
                req_rd = '0;
            end
            if (!REQ_WAIT_OUT[1]) begin nlow1++; req_wr = '0; end
        end
        chk("to_strobe_cycles", nrd, TO);
        chk("to_err_pulses", nerr, 1);
        chk("to_next_grant", first_adr, 10'h2AA);
        chk("to_next_done", nlow1, 1);

        // simultaneous wr+rd from requester 1
        req_wr = 3'b010; req_rd = 3'b010;
        nwr = 0; nrd = 0; nlow = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (RCFG_WR_OUT) nwr++;
            if (RCFG_RD_OUT) nrd++;
            if (!REQ_WAIT_OUT[1]) begin nlow++; req_wr = '0; req_rd = '0; end
        end
        chk("both_wr", nwr, 1);
        chk("both_rd", nrd, 0);
        chk("both_done", nlow, 1);

        // reset while a write to requester 2 is on the master port
        req_adr[0 +: A] = 10'h011; req_adr[2*A +: A] = 10'h022;
        req_wr = 3'b101; rcfg_wait = 1'b1;
        cyc();
        cyc();
        chk("pre_rst_adr", RCFG_ADR_OUT, 10'h022);
        pulse_reset();
        chk("mid_rst_wr", RCFG_WR_OUT, 1'b0);
        chk("mid_rst_wait", REQ_WAIT_OUT, 3'b111);
        rcfg_wait = 1'b0;
        cyc();
        chk("post_rst_grant", RCFG_ADR_OUT, 10'h011);
        for (int c = 0; c < 6; c++) begin
            cyc();
            for (int i = 0; i < P_REQS; i++) if (!REQ_WAIT_OUT[i]) req_wr[i] = 1'b0;
        end

        // randomized traffic
        req_wr = '0; req_rd = '0; pend = '0; wr_v = '0; rd_v = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < P_REQS; i++) begin
                if (pend[i] && !REQ_WAIT_OUT[i]) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && $urandom_range(0, 39) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    kind    = int'($urandom_range(0, 3));
                    wr_v[i] = (kind != 2);
                    rd_v[i] = (kind >= 2);
                    req_adr[i*A +: A] = A'($urandom);
                    req_dat[i*D +: D] = $urandom;
                end
            end
            req_wr    = pend & wr_v;
            req_rd    = pend & rd_v;
            rcfg_wait = ($urandom_range(0, 9) < 6);
            rcfg_dat  = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
